stim_capture: RTL and testbench
===============================

# stim_capture

Self-checking stimulus and capture engine for the arithmetic datapath `top`. It drives pseudo-random operands into the datapath's `a`, `b`, `c` and `e` inputs and collects the 13-bit `y` results into a FIFO. Capture is aligned to the datapath latency. A host or bench reads the captured results out through a simple read port. It sits beside `top` in the FPGA/bring-up build as the hardware counterpart of the bench stimulus loop.

## Interface
- `W`, 12: operand width for `a`, `b` and `c`.
- `YW`, 13: result width for `y`.
- `LAT`, 8: datapath latency in cycles from an operand appearing on `a` to the matching `y`. Legal range 1–31.
- `DEPTH`, 32: capture FIFO depth. Must be a power of 2.
- `SEED`, 32'h1: initial LFSR state. A value of 0 is replaced by 1.

- `clk`  in  1: clock; all logic on the rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `start`  in  1: begin a run. Sampled only in IDLE or DONE.
- `count`  in  6: number of operand sets to drive, 0–63. Latched on `start`.
- `busy`  out  1: high in DRIVE and DRAIN.
- `done`  out  1: 1-cycle pulse at the end of a run.
- `a`, `b`, `c`  out  W: operands to `top`. Registered.
- `e`  out  1: select bit to `top`. Registered.
- `y`  in  YW: result from `top`.
- `rd_en`  in  1: pop request.
- `rd_data`  out  YW: popped result. Registered.
- `rd_valid`  out  1: high for 1 cycle when `rd_data` is updated.
- `empty`, `full`  out  1: FIFO status.
- `overflow`  out  1: sticky flag, set when a result is dropped because the FIFO is full. Cleared on an accepted `start`.
- `level`  out  log2(DEPTH)+1: FIFO occupancy.

## Operation
- **FSM states:** IDLE, DRIVE, DRAIN, DONE.
- **IDLE or DONE:**
  - `start` with `count` > 0 → DRIVE.
  - `start` with `count` = 0 → DONE, and `done` pulses.
  - Leaving DONE with no `start` → IDLE after one cycle.
- **`start` is ignored in DRIVE and DRAIN.**
- **LFSR:** 32-bit Galois, shifting right. When the LSB is 1, the next state is `(s>>1)^32'h80200003`; otherwise it is `s>>1`. It advances once per DRIVE cycle, before its value is used.
- **Operand mapping:**
  - `a` = `s[11:0]`
  - `b` = `s[23:12]`
  - `c` = `s[31:20]`
  - `e` = `s[31]^s[0]`
- **LFSR state across runs:** the LFSR is not reseeded between runs; only `rst` reloads `SEED`.
- **Outside DRIVE:** `a`, `b`, `c` and `e` are held at 0.
- **Valid delay line:** a LAT-stage shift register carries a valid bit for each driven set. When the delayed bit is 1, `y` is pushed to the FIFO. If the FIFO is full, the sample is dropped and `overflow` is set.
- **DRIVE → DRAIN:** after `count` sets have been driven.
- **DRAIN → DONE:** when the delay line is empty. `done` pulses on entry to DONE.
- **FIFO push and pop:**
  - A push and a pop in the same cycle are both performed and `level` is unchanged.
  - When full, a same-cycle pop makes room and the push succeeds.
  - A pop when empty is ignored and `rd_valid` stays 0.
- **Reset values:**
  - All outputs 0, except `empty` = 1.
  - FSM in IDLE, LFSR = `SEED`, FIFO empty, delay line cleared.
  - A reset during DRIVE or DRAIN aborts the run immediately; results still in flight are discarded.

## Timing
- `start` accepted at edge T (with `count` = N) → the first operand set is on `a`..`e` during cycle T+1, and the last during cycle T+N.
- An operand set visible in cycle k → `y` is sampled in cycle k+LAT.
- The last push happens in cycle T+N+LAT; `done` is high in cycle T+N+LAT+1.
- `busy` is high from cycle T+1 through T+N+LAT.
- `rd_en` high in cycle k with FIFO non-empty → `rd_data` and `rd_valid` appear in cycle k+1.
- `level`, `empty` and `full` update in the cycle after a push or pop.

## Test plan
- **Reset:** hold `rst` for 3 cycles mid-DRIVE → all outputs 0, `empty` = 1, and a later run reproduces the post-reset sequence exactly.
- **Sequence check:** `SEED`=1, `start` with `count`=2 →
  - first set: `a`=0x003, `b`=0x200, `c`=0x802, `e`=0
  - second set: `a`=0x002, `b`=0x300, `c`=0xC03, `e`=1
  - `done` at T+11 (LAT=8).
- **Loopback:** connect `y` to a LAT-cycle delayed `{1'b0, a}`, run `count`=20 → 20 pops return exactly the driven `a` values in order; `overflow` = 0.
- **Overflow:** `DEPTH`=32, run `count`=40 with no reads → `full`=1, `level`=32, `overflow`=1, and the first 32 results are retained.
- **Empty start and start while busy:** `count`=0 → `done` at T+1, `busy` never high. A `start` pulse while `busy` → ignored, and the run length is unchanged.
- **Simultaneous push and pop at full:** run with `rd_en` held high from the first capture → `level` stays ≤ 1 and no data is lost.

Source files
------------

// File: rtl/stim_capture.sv
// Stimulus and capture engine for the arithmetic datapath: drives LFSR operands,
// aligns a valid bit to the datapath latency and buffers results in a read FIFO.
module stim_capture #(
   parameter int          W     = 12,
   parameter int          YW    = 13,
   parameter int          LAT   = 8,
   parameter int          DEPTH = 32,
   parameter logic [31:0] SEED  = 32'h1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [5:0]               count,
   output logic                     busy,
   output logic                     done,
   output logic [W-1:0]             a,
   output logic [W-1:0]             b,
   output logic [W-1:0]             c,
   output logic                     e,
   input  logic [YW-1:0]            y,
   input  logic                     rd_en,
   output logic [YW-1:0]            rd_data,
   output logic                     rd_valid,
   output logic                     empty,
   output logic                     full,
   output logic                     overflow,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int          AW       = $clog2(DEPTH);
   localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;
   localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_DRAIN, S_DONE} state_t;

   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      lfsr_step = s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
   endfunction

   state_t          state;
   state_t          state_nx;
   logic [5:0]      remain;
   logic [31:0]     lfsr;
   logic [31:0]     lfsr_nx;
   logic            accept;
   logic            drive_nx;
   logic [LAT:0]    vld_line;
   logic            pending;

   logic [YW-1:0]   mem [DEPTH];
   logic [AW-1:0]   wptr;
   logic [AW-1:0]   rptr;
   logic            push_req;
   logic            push;
   logic            pop;
   logic            drop;

   assign accept   = start && ((state == S_IDLE) || (state == S_DONE));
   assign drive_nx = (accept && (count != 6'd0)) || ((state == S_DRIVE) && (remain != 6'd0));
   assign lfsr_nx  = lfsr_step(lfsr);
   // Everything still in flight except the sample being captured this cycle
   assign pending  = |vld_line[LAT-1:0];

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_IDLE;
         remain <= 6'd0;
      end else begin
         state <= state_nx;
         if (accept && (count != 6'd0)) begin
            remain <= count - 6'd1;
         end else if ((state == S_DRIVE) && (remain != 6'd0)) begin
            remain <= remain - 6'd1;
         end
      end
   end

   // FSM next state
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_nx = (count != 6'd0) ? S_DRIVE : S_DONE;
            end else begin
               state_nx = S_IDLE;
            end
         end
         S_DRIVE: begin
            if (remain == 6'd0) begin
               state_nx = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (!pending) begin
               state_nx = S_DONE;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      busy = (state == S_DRIVE) || (state == S_DRAIN);
      done = (state == S_DONE);
   end

   // Stage p0: operands and their valid bit leave together
   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr     <= SEED_EFF;
         a        <= '0;
         b        <= '0;
         c        <= '0;
         e        <= 1'b0;
         vld_line <= '0;
      end else begin
         vld_line <= {vld_line[LAT-1:0], drive_nx};
         if (drive_nx) begin
            lfsr <= lfsr_nx;
            a    <= W'(lfsr_nx[11:0]);
            b    <= W'(lfsr_nx[23:12]);
            c    <= W'(lfsr_nx[31:20]);
            e    <= lfsr_nx[31] ^ lfsr_nx[0];
         end else begin
            a <= '0;
            b <= '0;
            c <= '0;
            e <= 1'b0;
         end
      end
   end

   assign push_req = vld_line[LAT];
   assign pop      = rd_en && !empty;
   // A same-cycle pop frees the slot the push needs when full
   assign push     = push_req && (!full || pop);
   assign drop     = push_req && full && !pop;
   assign empty    = (level == '0);
   assign full     = (level == LVL_FULL);

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wptr] <= y;
      end
   end

   // Stage p1: capture FIFO pointers, occupancy and read port
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr     <= '0;
         rptr     <= '0;
         level    <= '0;
         rd_valid <= 1'b0;
         rd_data  <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) begin
            wptr <= wptr + 1'b1;
         end
         if (pop) begin
            rptr    <= rptr + 1'b1;
            rd_data <= mem[rptr];
         end
         rd_valid <= pop;
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
         if (accept) begin
            overflow <= 1'b0;
         end else if (drop) begin
            overflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_stim_capture.sv
// Directed bench for stim_capture: y is looped back from a through a LAT-deep
// delay, and each run is checked for operands, timing, FIFO status and read data.
module tb_stim_capture;

   localparam int          W     = 12;
   localparam int          YW    = 13;
   localparam int          LAT   = 8;
   localparam int          DEPTH = 32;
   localparam logic [31:0] SEED  = 32'h1;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [5:0]    count;
   logic          busy, done;
   logic [W-1:0]  a, b, c;
   logic          e;
   logic [YW-1:0] y;
   logic          rd_en;
   logic [YW-1:0] rd_data;
   logic          rd_valid, empty, full, overflow;
   logic [5:0]    level;

   stim_capture #(.W(W), .YW(YW), .LAT(LAT), .DEPTH(DEPTH), .SEED(SEED)) dut (
      .clk(clk), .rst(rst), .start(start), .count(count), .busy(busy), .done(done),
      .a(a), .b(b), .c(c), .e(e), .y(y), .rd_en(rd_en), .rd_data(rd_data),
      .rd_valid(rd_valid), .empty(empty), .full(full), .overflow(overflow), .level(level)
   );

   always #5 clk = ~clk;

   logic [W-1:0] ydl [LAT];
   always @(posedge clk) begin
      for (int i = LAT-1; i > 0; i--) ydl[i] <= ydl[i-1];
      ydl[0] <= a;
   end
   assign y = {1'b0, ydl[LAT-1]};

   typedef struct {
      int n;
      bit rd;
      int exp_level;
      bit exp_full;
      bit exp_ovf;
   } vec_t;

   int           checks   = 0;
   int           failures = 0;
   logic [31:0]  mstate;
   logic [11:0]  expq[$];
   logic [36:0]  obs [2];
   vec_t         vecs [6];

   function automatic logic [31:0] lfsr_next(input logic [31:0] s);
      return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic pop_chk(input logic [YW-1:0] req, input bit req_v);
      @(negedge clk) rd_en = 1'b1;
      @(negedge clk) rd_en = 1'b0;
      chk("rd_valid", rd_valid, req_v);
      if (req_v) chk("rd_data", rd_data, req);
   endtask

   task automatic chk_reset_state();
      chk("rst_outputs", {busy, done, a, b, c, e, rd_data, rd_valid, full, overflow, level}, '0);
      chk("rst_empty", empty, 1'b1);
   endtask

   // One complete run; poke > 0 pulses start with a different count at that cycle
   task automatic run(input int n, input bit rd, input int poke,
                      input int exp_level, input bit exp_full, input bit exp_ovf);
      int done_t, done_cnt, busy_cnt, busy_first, max_lvl, limit;
      logic [YW-1:0] got[$];
      done_t = 0; done_cnt = 0; busy_cnt = 0; busy_first = 0; max_lvl = 0;
      limit = n + LAT + 6;
      @(negedge clk);
      rd_en = rd; start = 1'b1; count = n[5:0];
      @(posedge clk);
      #1 start = 1'b0; count = 6'd0;
      for (int t = 1; t <= limit; t++) begin
         @(negedge clk);
         if (t <= 2) obs[t-1] = {a, b, c, e};
         if (t <= n) begin
            mstate = lfsr_next(mstate);
            expq.push_back(mstate[11:0]);
            chk("op_abce", {a, b, c, e},
                {mstate[11:0], mstate[23:12], mstate[31:20], mstate[31] ^ mstate[0]});
         end else if (t == n + 1) begin
            chk("op_idle", {a, b, c, e}, '0);
         end
         if (busy) begin busy_cnt++; if (busy_first == 0) busy_first = t; end
         if (done) begin done_cnt++; if (done_t == 0) done_t = t; end
         if (int'(level) > max_lvl) max_lvl = int'(level);
         if (rd_valid) got.push_back(rd_data);
         start = (t == poke);
         count = (t == poke) ? 6'd7 : 6'd0;
      end
      rd_en = 1'b0;
      chk("done_time", done_t, (n == 0) ? 1 : n + LAT + 1);
      chk("done_width", done_cnt, 1);
      chk("busy_cycles", busy_cnt, (n == 0) ? 0 : n + LAT);
      chk("busy_first", busy_first, (n == 0) ? 0 : 1);
      chk("overflow", overflow, exp_ovf);
      chk("full", full, exp_full);
      chk("level", level, exp_level);
      if (rd) begin
         chk("rd_max_level_le1", max_lvl <= 1, 1'b1);
         chk("rd_count", got.size(), n);
         for (int i = 0; i < n && i < got.size(); i++)
            chk("rd_stream", got[i], {1'b0, expq[i]});
      end else begin
         for (int i = 0; i < exp_level; i++) pop_chk({1'b0, expq[i]}, 1'b1);
         pop_chk('0, 1'b0);
         chk("empty_after_drain", empty, 1'b1);
      end
      expq.delete();
   endtask

   initial begin
      vecs[0] = '{n: 20, rd: 1'b0, exp_level: 20, exp_full: 1'b0, exp_ovf: 1'b0};
      vecs[1] = '{n: 0,  rd: 1'b0, exp_level: 0,  exp_full: 1'b0, exp_ovf: 1'b0};
      vecs[2] = '{n: 40, rd: 1'b0, exp_level: 32, exp_full: 1'b1, exp_ovf: 1'b1};
      vecs[3] = '{n: 1,  rd: 1'b0, exp_level: 1,  exp_full: 1'b0, exp_ovf: 1'b0};
      vecs[4] = '{n: 40, rd: 1'b1, exp_level: 0,  exp_full: 1'b0, exp_ovf: 1'b0};
      vecs[5] = '{n: 63, rd: 1'b1, exp_level: 0,  exp_full: 1'b0, exp_ovf: 1'b0};

      rst = 1'b1; start = 1'b0; count = 6'd0; rd_en = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset_state();
      rst = 1'b0;
      mstate = SEED;

      run(2, 1'b0, 0, 2, 1'b0, 1'b0);
      chk("seq_set1", obs[0], {12'h003, 12'h200, 12'h802, 1'b0});
      chk("seq_set2", obs[1], {12'h002, 12'h300, 12'hC03, 1'b1});

      for (int i = 0; i < 6; i++)
         run(vecs[i].n, vecs[i].rd, 0, vecs[i].exp_level, vecs[i].exp_full, vecs[i].exp_ovf);

      run(5, 1'b0, 3, 5, 1'b0, 1'b0);

      @(negedge clk) start = 1'b1; count = 6'd10;
      @(negedge clk) start = 1'b0; count = 6'd0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk_reset_state();
      rst = 1'b0;
      mstate = SEED;
      expq.delete();
      @(negedge clk);
      chk("post_reset_level", level, 6'd0);
      run(2, 1'b0, 0, 2, 1'b0, 1'b0);
      chk("reseq_set1", obs[0], {12'h003, 12'h200, 12'h802, 1'b0});
      chk("reseq_set2", obs[1], {12'h002, 12'h300, 12'hC03, 1'b1});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
